// File: rtl/distribute_out_datas_if.sv
// Handshake and lane-slot bus between a word source and the lane distributor.
// The master drives the fill request and the word stream; the slave (the
// distributor) returns flow control, the lane slots and the status flags.
interface distribute_out_datas_if #(
  parameter int NUM   = 8,
  parameter int WIDTH = 5
);
  logic                   start_i;
  logic [NUM-1:0]         lane_mask_i;
  logic [WIDTH-1:0]       data_i;
  logic                   valid_i;
  logic                   ready_o;
  logic [NUM*WIDTH-1:0]   data_o;
  logic [NUM-1:0]         wr_o;
  logic                   busy_o;
  logic                   done_o;

  modport master (
    output start_i, lane_mask_i, data_i, valid_i,
    input  ready_o, data_o, wr_o, busy_o, done_o
  );

  modport slave (
    input  start_i, lane_mask_i, data_i, valid_i,
    output ready_o, data_o, wr_o, busy_o, done_o
  );
endinterface

// File: rtl/distribute_out_datas.sv
// Lane distributor: scatters a serial stream of WIDTH-bit words into NUM lane
// slots, lowest unfilled lane of the round's mask first, one word per cycle.
// Every output is a register; a write shows up on data_o/wr_o the cycle after
// the word is accepted, and the final write coincides with the done pulse.
module distribute_out_datas #(
  parameter int NUM   = 8,
  parameter int WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  distribute_out_datas_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [NUM-1:0]       r_rem_mask;
  logic [NUM*WIDTH-1:0] r_data;
  logic [NUM-1:0]       r_wr;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;

  logic [NUM-1:0]       w_pick;
  logic                 w_accept;
  logic                 w_last;

  // Isolate the lowest set bit of the remaining mask (lane 0 has priority,
  // matching the reducer) and flag when it is the final lane of the round.
  assign w_pick   = r_rem_mask & (~r_rem_mask + NUM'(1));
  assign w_last   = ((r_rem_mask & ~w_pick) == {NUM{1'b0}});
  assign w_accept = bus.valid_i & r_ready;

  // Round sequencer with registered handshake, strobe, status and lane slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rem_mask <= {NUM{1'b0}};
      r_data     <= {(NUM*WIDTH){1'b0}};
      r_wr       <= {NUM{1'b0}};
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // Strobe and done are single-cycle pulses unless re-armed below.
      r_wr   <= {NUM{1'b0}};
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b0;
          if (bus.start_i) begin
            r_rem_mask <= bus.lane_mask_i;
            r_busy     <= 1'b1;
            if (bus.lane_mask_i != {NUM{1'b0}}) begin
              r_state <= SEND;
              r_ready <= 1'b1;
            end else begin
              // Nothing to fill: report completion on the very next cycle.
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        SEND: begin
          if (w_accept) begin
            r_wr       <= w_pick;
            r_rem_mask <= r_rem_mask & ~w_pick;
            for (int k = 0; k < NUM; k++) begin
              if (w_pick[k]) begin
                r_data[k*WIDTH +: WIDTH] <= bus.data_i;
              end
            end
            if (w_last) begin
              // Done pulse lands in the same cycle as the last strobe.
              r_state <= DONE;
              r_ready <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_rem_mask <= {NUM{1'b0}};
          r_ready    <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o = r_ready;
  assign bus.data_o  = r_data;
  assign bus.wr_o    = r_wr;
  assign bus.busy_o  = r_busy;
  assign bus.done_o  = r_done;

endmodule

// File: tb/tb_distribute_out_datas.sv
// Self-checking bench for distribute_out_datas (NUM=8, WIDTH=5).
// Accepted words are pushed to a scoreboard with the lane the reference model
// picks; a negedge monitor pops on every strobe and checks strobe and slots.
module tb_distribute_out_datas;
  localparam int NUM   = 8;
  localparam int WIDTH = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  distribute_out_datas_if #(.NUM(NUM), .WIDTH(WIDTH)) bus ();
  distribute_out_datas #(.NUM(NUM), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int               lane;
    logic [WIDTH-1:0] d;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] model_slot [NUM];
  logic [NUM-1:0]   model_rem;
  int               errors = 0;
  int               checks = 0;
  int               wr_count = 0;
  int               done_count = 0;

  function automatic logic [NUM*WIDTH-1:0] model_packed();
    logic [NUM*WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < NUM; k++) v[k*WIDTH +: WIDTH] = model_slot[k];
    return v;
  endfunction

  // Monitor: every strobe must match the oldest scoreboard entry and the
  // whole slot vector must match the reference slots afterwards.
  always @(negedge clk) begin : monitor
    exp_t           e;
    logic [NUM-1:0] exp_wr;
    if (bus.done_o === 1'b1) done_count++;
    if (bus.wr_o !== '0) begin
      wr_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: wr_o=%h but nothing was accepted", bus.wr_o);
      end else begin
        e = sb.pop_front();
        exp_wr = '0;
        exp_wr[e.lane] = 1'b1;
        if (bus.wr_o !== exp_wr) begin
          errors++;
          $display("FAIL wr_onehot: wr_o=%h expected %h", bus.wr_o, exp_wr);
        end
        model_slot[e.lane] = e.d;
        checks++;
        if (bus.data_o !== model_packed()) begin
          errors++;
          $display("FAIL slots: data_o=%h expected %h", bus.data_o, model_packed());
        end
      end
    end
  end

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic send_word(input logic [WIDTH-1:0] d, output int waited);
    bit got;
    int lane;
    got = 1'b0;
    waited = 0;
    bus.valid_i = 1'b1;
    bus.data_i  = d;
    for (int c = 0; c < 20 && !got; c++) begin
      if (bus.ready_o === 1'b1) begin
        lane = -1;
        for (int i = 0; i < NUM; i++) if (model_rem[i] && lane < 0) lane = i;
        if (lane >= 0) begin
          sb.push_back('{lane, d});
          model_rem[lane] = 1'b0;
        end
        got = 1'b1;
      end
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_timeout: ready_o=%b word=%h not accepted in 20 cycles", bus.ready_o, d);
    end
  endtask

  task automatic start_round(input logic [NUM-1:0] mask);
    bus.start_i     = 1'b1;
    bus.lane_mask_i = mask;
    model_rem       = mask;
    @(posedge clk); #1;
    bus.start_i     = 1'b0;
    bus.lane_mask_i = 8'h5A;
  endtask

  task automatic check_round_end(input string name, input int w0, input int d0, input int n);
    checks++;
    if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b1 || bus.ready_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: done=%b busy=%b ready=%b expected 1 1 0", name, bus.done_o, bus.busy_o, bus.ready_o);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: done=%b busy=%b ready=%b expected 0 0 0", name, bus.done_o, bus.busy_o, bus.ready_o);
    end
    checks++;
    if (wr_count - w0 !== n || done_count - d0 !== 1 || sb.size() !== 0) begin
      errors++;
      $display("FAIL %s_count: strobes=%0d dones=%0d pending=%0d expected %0d 1 0", name, wr_count - w0, done_count - d0, sb.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.data_o !== '0 || bus.wr_o !== '0 || bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: data=%h wr=%h ready=%b busy=%b done=%b expected all 0", bus.data_o, bus.wr_o, bus.ready_o, bus.busy_o, bus.done_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full();
    int w0, d0, wt, tot;
    w0 = wr_count; d0 = done_count; tot = 0;
    start_round(8'hFF);
    for (int i = 1; i <= 8; i++) begin
      send_word(WIDTH'(i), wt);
      tot += wt;
    end
    bus.valid_i = 1'b0;
    checks++;
    if (bus.wr_o !== 8'h80) begin
      errors++;
      $display("FAIL full_last_wr: wr_o=%h expected 80", bus.wr_o);
    end
    checks++;
    if (tot !== 8) begin
      errors++;
      $display("FAIL full_b2b: cycles=%0d expected 8", tot);
    end
    check_round_end("full", w0, d0, 8);
  endtask

  task automatic test_sparse();
    int w0, d0, wt;
    logic [WIDTH-1:0] ws [3];
    ws[0] = 5'h1A; ws[1] = 5'h0B; ws[2] = 5'h13;
    w0 = wr_count; d0 = done_count;
    start_round(8'b1010_0100);
    for (int i = 0; i < 3; i++) send_word(ws[i], wt);
    bus.valid_i = 1'b0;
    check_round_end("sparse", w0, d0, 3);
    checks++;
    if (bus.data_o[2*WIDTH +: WIDTH] !== 5'h1A || bus.data_o[5*WIDTH +: WIDTH] !== 5'h0B ||
        bus.data_o[7*WIDTH +: WIDTH] !== 5'h13 || bus.data_o[0 +: WIDTH] !== 5'h01 ||
        bus.data_o[6*WIDTH +: WIDTH] !== 5'h07) begin
      errors++;
      $display("FAIL sparse_slots: data_o=%h", bus.data_o);
    end
  endtask

  task automatic test_stall();
    int w0, d0, wt;
    w0 = wr_count; d0 = done_count;
    start_round(8'hFF);
    send_word(5'h11, wt);
    send_word(5'h12, wt);
    bus.valid_i = 1'b0;
    for (int g = 0; g < 3; g++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.wr_o !== '0 || bus.ready_o !== 1'b1) begin
        errors++;
        $display("FAIL stall_gap%0d: wr_o=%h ready=%b expected 00 1", g, bus.wr_o, bus.ready_o);
      end
    end
    for (int i = 3; i <= 8; i++) send_word(WIDTH'(5'h10 + i), wt);
    bus.valid_i = 1'b0;
    check_round_end("stall", w0, d0, 8);
  endtask

  task automatic test_empty();
    int w0, d0;
    w0 = wr_count; d0 = done_count;
    start_round(8'h00);
    check_round_end("empty", w0, d0, 0);
  endtask

  task automatic test_start_mid();
    int w0, d0, wt;
    w0 = wr_count; d0 = done_count;
    start_round(8'hFF);
    for (int i = 0; i < 3; i++) send_word(WIDTH'(5'h15 + i), wt);
    bus.start_i = 1'b1;
    bus.lane_mask_i = 8'h01;
    send_word(5'h1F, wt);
    bus.start_i = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b1 || bus.ready_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_start_ignored: busy=%b ready=%b expected 1 1", bus.busy_o, bus.ready_o);
    end
    for (int i = 0; i < 4; i++) send_word(WIDTH'(5'h03 + i), wt);
    bus.valid_i = 1'b0;
    check_round_end("midstart", w0, d0, 8);
  endtask

  task automatic test_reset_mid();
    int w0, d0, wt;
    start_round(8'hFF);
    for (int i = 0; i < 3; i++) send_word(WIDTH'(5'h09 + i), wt);
    w0 = wr_count; d0 = done_count;
    bus.valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < NUM; k++) model_slot[k] = '0;
    model_rem = '0;
    checks++;
    if (bus.data_o !== '0 || bus.wr_o !== '0 || bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: data=%h wr=%h ready=%b busy=%b done=%b expected all 0", bus.data_o, bus.wr_o, bus.ready_o, bus.busy_o, bus.done_o);
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (done_count !== d0 + 1 - 1 + (wr_count - w0 - 1) || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_quiet: dones=%0d strobes=%0d busy=%b expected 0 1 0", done_count - d0, wr_count - w0, bus.busy_o);
    end
    w0 = wr_count; d0 = done_count;
    start_round(8'h0F);
    for (int i = 0; i < 4; i++) send_word(WIDTH'(5'h07 + i), wt);
    bus.valid_i = 1'b0;
    check_round_end("rstmid_new", w0, d0, 4);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Test sequence.
  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.lane_mask_i = '0;
    bus.data_i = '0;
    bus.valid_i = 1'b0;
    model_rem = '0;
    for (int k = 0; k < NUM; k++) model_slot[k] = '0;
    test_reset();
    test_full();
    test_sparse();
    test_stall();
    test_empty();
    test_start_mid();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
